controle_comida: RTL and testbench



---
 rtl/controle_comida_pkg.sv | 31 +++
 rtl/controle_comida_contador.sv | 46 ++++
 rtl/controle_comida.sv | 181 ++++++++++++++++++
 tb/tb_controle_comida.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_comida_pkg.sv
// -----------------------------------------------------------------------------
// controle_comida_pkg
// Shared definitions for the food-placement controller and its neighbours.
//   - LARGURA / ALTURA : default grid size (also used by board memory and
//                        renderer, so they live here rather than in the FSM)
//   - INTERVALO_PAD / MAX_TENTATIVAS_PAD : default sampling interval and the
//                        number of random draws before the linear scan
//   - estado_t         : controller state encoding
//   - largura_contador : counter width for a modulo-N counter (at least 1 bit)
// -----------------------------------------------------------------------------
package controle_comida_pkg;

    localparam int LARGURA            = 16;
    localparam int ALTURA             = 16;
    localparam int INTERVALO_PAD      = 4;
    localparam int MAX_TENTATIVAS_PAD = 15;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ESPERA_X  = 3'd1,
        ESPERA_Y  = 3'd2,
        VERIFICA  = 3'd3,
        VARREDURA = 3'd4,
        FIM       = 3'd5
    } estado_t;

    function automatic int largura_contador(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/controle_comida_contador.sv
// -----------------------------------------------------------------------------
// contador_intervalo
// Modulo-INTERVALO counter that paces sampling of the free-running random
// nibble. Counts while enabled, wraps to 0 on its own terminal count.
//   clock      in  system clock, rising edge
//   reset_n    in  asynchronous active-low reset
//   limpa_i    in  synchronous clear (holds the count at 0)
//   habilita_i in  count enable
//   terminal_o out high in the cycle the count sits at INTERVALO-1 while enabled
// -----------------------------------------------------------------------------
module contador_intervalo #(
    parameter int INTERVALO = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic limpa_i,
    input  logic habilita_i,
    output logic terminal_o
);
    import controle_comida_pkg::*;

    localparam int            CW     = largura_contador(INTERVALO);
    localparam logic [CW-1:0] ULTIMO = CW'(INTERVALO - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign terminal_o = habilita_i && (cnt_q == ULTIMO);

    always_comb begin
        cnt_d = cnt_q;
        if (limpa_i || terminal_o) begin
            cnt_d = '0;
        end else if (habilita_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/controle_comida.sv
// -----------------------------------------------------------------------------
// controle_comida
// Places one food item on the snake grid. On request it samples an X and then
// a Y candidate from the random nibble (one sample every INTERVALO cycles),
// checks the candidate against the board occupancy map and retries on
// collision. After MAX_TENTATIVAS failed draws it scans the board linearly
// and takes the first free cell, or reports that the board is full.
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   pedido         in   placement request (only honoured when idle)
//   aleatorio      in   random nibble from the generator
//   ocupado_celula in   occupancy of (consulta_x, consulta_y), same cycle
//   consulta_x/_y  out  cell being checked; hold last value otherwise
//   comida_x/_y    out  placed food position, held between placements
//   valido         out  one-cycle pulse: new comida_x/_y
//   falha          out  one-cycle pulse: no free cell found
//   ocupado        out  controller busy
// -----------------------------------------------------------------------------
module controle_comida #(
    parameter int INTERVALO      = controle_comida_pkg::INTERVALO_PAD,
    parameter int MAX_TENTATIVAS = controle_comida_pkg::MAX_TENTATIVAS_PAD,
    parameter int LARGURA        = controle_comida_pkg::LARGURA,
    parameter int ALTURA         = controle_comida_pkg::ALTURA
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pedido,
    input  logic [3:0] aleatorio,
    input  logic       ocupado_celula,
    output logic [3:0] consulta_x,
    output logic [3:0] consulta_y,
    output logic [3:0] comida_x,
    output logic [3:0] comida_y,
    output logic       valido,
    output logic       falha,
    output logic       ocupado
);
    import controle_comida_pkg::*;

    localparam logic [3:0] MAX_T = 4'(MAX_TENTATIVAS);

    estado_t    estado_q, estado_d;
    logic [3:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [3:0] tent_q, tent_d;
    logic [7:0] idx_q, idx_d;
    logic [3:0] cons_x_q, cons_x_d, cons_y_q, cons_y_d;
    logic [3:0] com_x_q, com_x_d, com_y_q, com_y_d;
    logic       falha_q, falha_d;
    logic       habilita, terminal;

    // Widen to int so a full 16x16 grid does not produce an always-true
    // 4-bit comparison.
    function automatic logic dentro(input logic [3:0] x, input logic [3:0] y);
        return (int'(x) < LARGURA) && (int'(y) < ALTURA);
    endfunction

    // One counter serves both waiting states; it is held at 0 everywhere
    // else so each wait window starts from a fresh count.
    assign habilita = (estado_q == ESPERA_X) || (estado_q == ESPERA_Y);

    contador_intervalo #(
        .INTERVALO (INTERVALO)
    ) u_contador (
        .clock      (clock),
        .reset_n    (reset_n),
        .limpa_i    (!habilita),
        .habilita_i (habilita),
        .terminal_o (terminal)
    );

    always_comb begin
        estado_d   = estado_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        tent_d     = tent_q;
        idx_d      = idx_q;
        com_x_d    = com_x_q;
        com_y_d    = com_y_q;
        falha_d    = 1'b0;
        consulta_x = cons_x_q;
        consulta_y = cons_y_q;

        case (estado_q)
            OCIOSO: begin
                if (pedido) begin
                    tent_d   = '0;
                    estado_d = ESPERA_X;
                end
            end
            ESPERA_X: begin
                if (terminal) begin
                    cand_x_d = aleatorio;
                    estado_d = ESPERA_Y;
                end
            end
            ESPERA_Y: begin
                if (terminal) begin
                    cand_y_d = aleatorio;
                    estado_d = VERIFICA;
                end
            end
            VERIFICA: begin
                consulta_x = cand_x_q;
                consulta_y = cand_y_q;
                if (dentro(cand_x_q, cand_y_q) && !ocupado_celula) begin
                    com_x_d  = cand_x_q;
                    com_y_d  = cand_y_q;
                    estado_d = FIM;
                end else begin
                    // Out-of-range candidates count as a failed draw too.
                    tent_d = tent_q + 4'd1;
                    if (tent_d == MAX_T) begin
                        idx_d    = '0;
                        estado_d = VARREDURA;
                    end else begin
                        estado_d = ESPERA_X;
                    end
                end
            end
            VARREDURA: begin
                consulta_x = idx_q[3:0];
                consulta_y = idx_q[7:4];
                if (dentro(idx_q[3:0], idx_q[7:4]) && !ocupado_celula) begin
                    com_x_d  = idx_q[3:0];
                    com_y_d  = idx_q[7:4];
                    estado_d = FIM;
                end else if (idx_q == 8'hFF) begin
                    falha_d  = 1'b1;
                    estado_d = OCIOSO;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        cons_x_d = consulta_x;
        cons_y_d = consulta_y;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            cand_x_q <= '0;
            cand_y_q <= '0;
            tent_q   <= '0;
            idx_q    <= '0;
            cons_x_q <= '0;
            cons_y_q <= '0;
            com_x_q  <= '0;
            com_y_q  <= '0;
            falha_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            tent_q   <= tent_d;
            idx_q    <= idx_d;
            cons_x_q <= cons_x_d;
            cons_y_q <= cons_y_d;
            com_x_q  <= com_x_d;
            com_y_q  <= com_y_d;
            falha_q  <= falha_d;
        end
    end

    // falha is registered because the FSM is already back in OCIOSO in the
    // cycle it is reported; valido is simply the one-cycle FIM state.
    assign comida_x = com_x_q;
    assign comida_y = com_y_q;
    assign valido   = (estado_q == FIM);
    assign falha    = falha_q;
    assign ocupado  = (estado_q == ESPERA_X) || (estado_q == ESPERA_Y) ||
                      (estado_q == VERIFICA) || (estado_q == VARREDURA);

endmodule

// File: tb/tb_controle_comida.sv
module tb_controle_comida;

    typedef struct packed {
        logic        falha;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [31:0] ciclo;
    } esperado_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         pedido = 1'b0;
    logic         pedido_b = 1'b0;
    logic [3:0]   aleatorio = 4'h0;
    logic [255:0] tabuleiro = '0;
    logic         ocupado_celula;
    logic         livre_b = 1'b0;
    logic [3:0]   consulta_x, consulta_y, comida_x, comida_y;
    logic         valido, falha, ocupado;
    logic [3:0]   consulta_x_b, consulta_y_b, comida_x_b, comida_y_b;
    logic         valido_b, falha_b, ocupado_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    esperado_t sb_a[$];
    esperado_t sb_b[$];
    esperado_t ea, eb;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Board memory model: combinational occupancy for the queried cell.
    assign ocupado_celula = tabuleiro[{consulta_y, consulta_x}];

    controle_comida dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pedido         (pedido),
        .aleatorio      (aleatorio),
        .ocupado_celula (ocupado_celula),
        .consulta_x     (consulta_x),
        .consulta_y     (consulta_y),
        .comida_x       (comida_x),
        .comida_y       (comida_y),
        .valido         (valido),
        .falha          (falha),
        .ocupado        (ocupado)
    );

    // Narrow grid instance: X candidates >= 10 must be rejected.
    controle_comida #(.LARGURA(10)) dut_b (
        .clock          (clock),
        .reset_n        (reset_n),
        .pedido         (pedido_b),
        .aleatorio      (aleatorio),
        .ocupado_celula (livre_b),
        .consulta_x     (consulta_x_b),
        .consulta_y     (consulta_y_b),
        .comida_x       (comida_x_b),
        .comida_y       (comida_y_b),
        .valido         (valido_b),
        .falha          (falha_b),
        .ocupado        (ocupado_b)
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumers: every valido/falha pulse pops one expectation.
    always @(negedge clock) begin
        if (valido || falha) begin
            if (sb_a.size() == 0) begin
                verifica("a_pulso_inesperado", 32'({valido, falha}), 32'd0);
            end else begin
                ea = sb_a.pop_front();
                verifica("a_tipo", 32'({valido, falha}), ea.falha ? 32'd1 : 32'd2);
                verifica("a_ciclo", 32'(cyc), ea.ciclo);
                verifica("a_comida", 32'({comida_x, comida_y}), 32'({ea.x, ea.y}));
                verifica("a_ocupado_no_pulso", 32'(ocupado), 32'd0);
            end
        end
    end

    always @(negedge clock) begin
        if (valido_b || falha_b) begin
            if (sb_b.size() == 0) begin
                verifica("b_pulso_inesperado", 32'({valido_b, falha_b}), 32'd0);
            end else begin
                eb = sb_b.pop_front();
                verifica("b_tipo", 32'({valido_b, falha_b}), eb.falha ? 32'd1 : 32'd2);
                verifica("b_ciclo", 32'(cyc), eb.ciclo);
                verifica("b_comida", 32'({comida_x_b, comida_y_b}), 32'({eb.x, eb.y}));
                verifica("b_ocupado_no_pulso", 32'(ocupado_b), 32'd0);
            end
        end
    end

    task automatic passo(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic esperado_t monta(input logic f, input logic [3:0] x,
                                        input logic [3:0] y, input int c);
        esperado_t e;
        e.falha = f;
        e.x     = x;
        e.y     = y;
        e.ciclo = 32'(c);
        return e;
    endfunction

    // Request on dut; k is the cycle count just after the accepting edge.
    task automatic pede_a(output int k);
        pedido = 1'b1;
        passo(1);
        pedido = 1'b0;
        k = cyc;
        verifica("a_ocupado_apos_pedido", 32'(ocupado), 32'd1);
    endtask

    // One random draw: x held through the X latch edge, y through the Y latch
    // edge, then the verify edge. ruido keeps pedido high while busy.
    task automatic sorteio(input logic [3:0] x, input logic [3:0] y, input bit ruido);
        aleatorio = x;
        pedido = ruido;
        passo(4);
        aleatorio = y;
        passo(4);
        pedido = 1'b0;
        passo(1);
    endtask

    task automatic aguarda_fim(input string tag, input bit lado_b, input int limite);
        int n;
        n = 0;
        while ((lado_b ? (ocupado_b || valido_b) : (ocupado || valido)) && n < limite) begin
            passo(1);
            n++;
        end
        verifica(tag, 32'(n >= limite), 32'd0);
        passo(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic [3:0] rx, ry;

        // 1. Reset with random inputs, then idle with no request.
        for (int i = 0; i < 5; i++) begin
            pedido    = 1'($urandom);
            aleatorio = 4'($urandom);
            tabuleiro = {8{$urandom}};
            passo(1);
            verifica("reset_saidas_a", 32'({consulta_x, consulta_y, comida_x, comida_y,
                                             valido, falha, ocupado}), 32'd0);
            verifica("reset_saidas_b", 32'({consulta_x_b, consulta_y_b, comida_x_b, comida_y_b,
                                             valido_b, falha_b, ocupado_b}), 32'd0);
        end
        pedido = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            passo(1);
            verifica("ocioso_sem_pedido", 32'(ocupado), 32'd0);
        end

        // 2. Single draw, free cell.
        tabuleiro = '0;
        pede_a(k);
        sb_a.push_back(monta(1'b0, 4'd3, 4'd7, k + 9));
        sorteio(4'h3, 4'h7, 1'b0);
        aguarda_fim("t2_tempo", 1'b0, 50);

        // 3. One collision, pedido noise while busy and in FIM.
        tabuleiro = '0;
        tabuleiro[{4'd7, 4'd3}] = 1'b1;
        pede_a(k);
        sb_a.push_back(monta(1'b0, 4'd5, 4'd2, k + 18));
        sorteio(4'h3, 4'h7, 1'b1);
        sorteio(4'h5, 4'h2, 1'b1);
        verifica("t3_valido_fim", 32'(valido), 32'd1);
        pedido = 1'b1;
        passo(1);
        pedido = 1'b0;
        aguarda_fim("t3_tempo", 1'b0, 50);

        // 4. Scan fallback: only (2,1) free, random draws avoid it.
        tabuleiro = '1;
        tabuleiro[{4'd1, 4'd2}] = 1'b0;
        pede_a(k);
        sb_a.push_back(monta(1'b0, 4'd2, 4'd1, k + 15 * 9 + 8'h12 + 1));
        for (int i = 0; i < 15; i++) begin
            rx = 4'($urandom);
            ry = 4'($urandom);
            if (rx == 4'd2 && ry == 4'd1) rx = 4'd3;
            sorteio(rx, ry, 1'b0);
        end
        aguarda_fim("t4_tempo", 1'b0, 300);

        // 5. Board full: falha, comida keeps (2,1).
        tabuleiro = '1;
        pede_a(k);
        sb_a.push_back(monta(1'b1, 4'd2, 4'd1, k + 15 * 9 + 256));
        for (int i = 0; i < 15; i++) begin
            sorteio(4'($urandom), 4'($urandom), 1'b0);
        end
        aguarda_fim("t5_tempo", 1'b0, 400);
        verifica("t5_comida_mantida", 32'({comida_x, comida_y}), 32'({4'd2, 4'd1}));

        // 6. Asynchronous reset during ESPERA_Y, then a clean draw.
        tabuleiro = '0;
        pede_a(k);
        aleatorio = 4'h9;
        passo(4);
        aleatorio = 4'h6;
        passo(2);
        #2 reset_n = 1'b0;
        #1 verifica("t6_reset_imediato", 32'({consulta_x, consulta_y, comida_x, comida_y,
                                               valido, falha, ocupado}), 32'd0);
        passo(2);
        reset_n = 1'b1;
        passo(2);
        pede_a(k);
        sb_a.push_back(monta(1'b0, 4'd3, 4'd7, k + 9));
        sorteio(4'h3, 4'h7, 1'b0);
        aguarda_fim("t6_tempo", 1'b0, 50);

        // 6b. Narrow grid: cand_x=12 rejected and counted, then (4,5).
        pedido_b = 1'b1;
        passo(1);
        pedido_b = 1'b0;
        k = cyc;
        verifica("b_ocupado_apos_pedido", 32'(ocupado_b), 32'd1);
        sb_b.push_back(monta(1'b0, 4'd4, 4'd5, k + 18));
        sorteio(4'd12, 4'd1, 1'b0);
        sorteio(4'd4, 4'd5, 1'b0);
        aguarda_fim("b_tempo", 1'b1, 50);

        passo(5);
        verifica("a_fila_vazia", 32'(sb_a.size()), 32'd0);
        verifica("b_fila_vazia", 32'(sb_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
